mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master single-port SRAM arbiter: core (m0) vs loader/debug (m1), zero-latency grant.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed core priority for alternation on contention.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  m0_req_i,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_wen_i,
  input  logic [3:0]            m0_wmask_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_wen_i,
  input  logic [3:0]            m1_wmask_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  mem_csb_o,
  output logic                  mem_web_o,
  output logic [3:0]            mem_wmask_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_din_o,
  input  logic [31:0]           mem_dout_i
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  owner_t     owner, owner_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       last_owner, last_nxt;   // 0: m0 granted last, 1: m1 granted last
  logic       gnt0, gnt1;
  logic       m0_vld_p1, m1_vld_p1;
  logic       unused_addr_bits;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Grant decision and next state; reset kills the grant combinationally.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_nxt = IDLE;
    hold_nxt  = 4'd0;
    last_nxt  = last_owner;
    if (!reset_i) begin
      if (m0_req_i && m1_req_i) begin
        // An unexpired m1 hold window outranks any other contention rule.
        if (owner == OWN1 && hold_cnt < HOLD_LIM) begin
          gnt1 = 1'b1;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
          gnt0 = last_owner;
          gnt1 = ~last_owner;
`else
          gnt0 = 1'b1;
`endif
        end
      end else begin
        gnt0 = m0_req_i;
        gnt1 = m1_req_i;
      end
    end
    if (gnt0) begin
      owner_nxt = OWN0;
      last_nxt  = 1'b0;
    end else if (gnt1) begin
      owner_nxt = OWN1;
      hold_nxt  = sat_inc(hold_cnt);
      last_nxt  = 1'b1;
    end
  end

  // Stage p0 -> p1: arbitration state and read-response valids.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner      <= IDLE;
      hold_cnt   <= 4'd0;
      last_owner <= 1'b0;
      m0_vld_p1  <= 1'b0;
      m1_vld_p1  <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= last_nxt;
      m0_vld_p1  <= gnt0 & m0_wen_i;
      m1_vld_p1  <= gnt1 & m1_wen_i;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign mem_csb_o   = ~(gnt0 | gnt1);
  assign mem_web_o   = gnt1 ? m1_wen_i   : (gnt0 ? m0_wen_i   : 1'b1);
  assign mem_wmask_o = gnt1 ? m1_wmask_i : (gnt0 ? m0_wmask_i : 4'd0);
  assign mem_addr_o  = gnt1 ? m1_addr_i[ADDR_WIDTH+1:2] : m0_addr_i[ADDR_WIDTH+1:2];
  assign mem_din_o   = gnt1 ? m1_wdata_i : m0_wdata_i;

  assign m0_rvalid_o = m0_vld_p1;
  assign m1_rvalid_o = m1_vld_p1;
  assign m0_rdata_o  = mem_dout_i;
  assign m1_rdata_o  = mem_dout_i;

  // Byte offset and bits above the SRAM depth do not select a word.
  assign unused_addr_bits = ^{m0_addr_i[31:ADDR_WIDTH+2], m0_addr_i[1:0],
                              m1_addr_i[31:ADDR_WIDTH+2], m1_addr_i[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: reference arbitration model, shadow memory and
// a behavioural SRAM; read responses are queued at grant time and checked on rvalid.
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int MH = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_csb, mem_web;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wen_i(m0_wen), .m0_wmask_i(m0_wmask),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wen_i(m1_wen), .m1_wmask_i(m1_wmask),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .mem_csb_o(mem_csb), .mem_web_o(mem_web), .mem_wmask_o(mem_wmask),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  // Behavioural SRAM driven only by the DUT's memory port.
  logic [31:0] sram [0:DEPTH-1];
  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= sram[mem_addr];
      end
    end
  end

  logic [31:0] shadow [0:DEPTH-1];

  typedef struct {
    bit          rv0;
    bit          rv1;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;
  int m_owner;   // 0 idle, 1 m0, 2 m1
  int m_hold;
  bit m_last;    // 0 m0, 1 m1

  function automatic logic [31:0] init_word(input int i);
    return {16'hC0DE ^ 16'(i * 7), 16'(i)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input bit req, input bit wen, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    m0_req = req; m0_wen = wen; m0_addr = addr; m0_wmask = mask; m0_wdata = data;
  endtask

  task automatic set_m1(input bit req, input bit wen, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    m1_req = req; m1_wen = wen; m1_addr = addr; m1_wmask = mask; m1_wdata = data;
  endtask

  task automatic model_reset();
    m_owner = 0; m_hold = 0; m_last = 0;
    sbq.delete();
  endtask

  // One clock cycle: check last cycle's response, check this cycle's grant, advance model.
  task automatic apply();
    exp_t        e, en;
    bit          g0, g1, wen;
    logic [AW-1:0] wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    #1;
    e.rv0 = 0; e.rv1 = 0; e.data = '0;
    if (sbq.size() > 0) e = sbq.pop_front();
    check_eq("m0_rvalid", m0_rvalid, e.rv0);
    check_eq("m1_rvalid", m1_rvalid, e.rv1);
    if (e.rv0) check_eq("m0_rdata", m0_rdata, e.data);
    if (e.rv1) check_eq("m1_rdata", m1_rdata, e.data);

    g0 = 0; g1 = 0;
    if (m0_req && m1_req) begin
      if (m_owner == 2 && m_hold < MH) g1 = 1;
      else begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m_last) g0 = 1; else g1 = 1;
`else
        g0 = 1;
`endif
      end
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
    check_eq("m0_gnt", m0_gnt, g0);
    check_eq("m1_gnt", m1_gnt, g1);
    check_eq("mem_csb", mem_csb, !(g0 || g1));

    en.rv0 = 0; en.rv1 = 0; en.data = '0;
    if (g0 || g1) begin
      wen = g1 ? m1_wen : m0_wen;
      wa  = g1 ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
      wd  = g1 ? m1_wdata : m0_wdata;
      wm  = g1 ? m1_wmask : m0_wmask;
      check_eq("mem_addr", mem_addr, wa);
      check_eq("mem_web", mem_web, wen);
      if (!wen) begin
        check_eq("mem_wmask", mem_wmask, wm);
        check_eq("mem_din", mem_din, wd);
        for (int b = 0; b < 4; b++)
          if (wm[b]) shadow[wa][8*b +: 8] = wd[8*b +: 8];
      end else begin
        en.rv0 = g0; en.rv1 = g1; en.data = shadow[wa];
      end
    end else begin
      check_eq("mem_web_idle", mem_web, 1'b1);
    end
    sbq.push_back(en);

    m_owner = g0 ? 1 : (g1 ? 2 : 0);
    m_hold  = g1 ? ((m_hold == 15) ? 15 : m_hold + 1) : 0;
    if (g0) m_last = 0;
    else if (g1) m_last = 1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m0_gnt"}, m0_gnt, 1'b0);
    check_eq({tag, "_m1_gnt"}, m1_gnt, 1'b0);
    check_eq({tag, "_m0_rvalid"}, m0_rvalid, 1'b0);
    check_eq({tag, "_m1_rvalid"}, m1_rvalid, 1'b0);
    check_eq({tag, "_csb"}, mem_csb, 1'b1);
    check_eq({tag, "_web"}, mem_web, 1'b1);
    check_eq({tag, "_wmask"}, mem_wmask, 4'd0);
  endtask

  initial begin
    int run, both0;
    bit seen0;
    reset = 1'b1;
    set_m0(0, 1, '0, '0, '0);
    set_m1(0, 1, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]   <= init_word(i);
      shadow[i]  = init_word(i);
    end
    model_reset();

    @(negedge clk); #1;
    check_reset_outputs("rst");
    set_m0(1, 1, 32'h0000_1E04, 4'hF, '0);
    #1;
    check_reset_outputs("rst_req");

    // Release reset with a core read already presented: granted in the first cycle.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("first_gnt", m0_gnt, 1'b1);
    check_eq("addr_781", mem_addr, 11'h781);
    apply();

    set_m0(0, 1, '0, '0, '0);
    set_m1(1, 0, 32'h0000_1E08, 4'b0011, 32'hDEAD_BEEF);
    apply();
    set_m1(0, 1, '0, '0, '0);
    set_m0(1, 1, 32'h0000_1E08, 4'hF, '0);
    apply();
    set_m0(0, 1, '0, '0, '0);
    #1;
    check_eq("partial_write", m0_rdata, {init_word(12'h782)>>16, 16'hBEEF} & 32'hFFFF_FFFF);
    apply();

    // Back-to-back reads from alternating masters.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        set_m0(1, 1, 32'(i * 4 + 16), 4'hF, '0); set_m1(0, 1, '0, '0, '0);
      end else begin
        set_m1(1, 1, 32'(i * 4 + 16), 4'hF, '0); set_m0(0, 1, '0, '0, '0);
      end
      apply();
    end
    set_m0(0, 1, '0, '0, '0); set_m1(0, 1, '0, '0, '0);
    apply();

    // m1 becomes owner alone, then both contend: hold window bounds m1's run.
    set_m1(1, 1, 32'h0000_0100, 4'hF, '0);
    run = 0; seen0 = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) set_m0(1, 1, 32'h0000_0200, 4'hF, '0);
      #1;
      if (!seen0) begin
        if (m0_gnt) seen0 = 1;
        else if (m1_gnt) run++;
      end
      apply();
    end
    check_eq("hold_run", run, MH);
    check_eq("hold_then_m0", seen0, 1'b1);

    set_m0(0, 1, '0, '0, '0); set_m1(0, 1, '0, '0, '0);
    apply();
    apply();

    // Both request from idle.
    set_m0(1, 1, 32'h0000_0040, 4'hF, '0);
    set_m1(1, 1, 32'h0000_0080, 4'hF, '0);
    both0 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (m0_gnt) both0++;
      apply();
    end
`ifndef ARB_ROUND_ROBIN_EN
    check_eq("fixed_prio", both0, 4);
`endif
    set_m0(0, 1, '0, '0, '0); set_m1(0, 1, '0, '0, '0);
    apply();

    // Random traffic, including dropped requests and masked writes.
    for (int i = 0; i < 300; i++) begin
      set_m0($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 4'($urandom), $urandom);
      set_m1($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 4'($urandom), $urandom);
      apply();
    end

    // Reset in the cycle after a read grant drops the response.
    set_m1(0, 1, '0, '0, '0);
    set_m0(1, 1, 32'h0000_0300, 4'hF, '0);
    apply();
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk); #1;
    check_reset_outputs("midrst2");
    @(negedge clk);
    reset = 1'b0;
    set_m0(0, 1, '0, '0, '0);
    apply();
    apply();
    apply();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
